// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter made of DIGITS cascaded decade stages.
// A count step ripples through the whole digit chain in one cycle. There is
// a parallel BCD load, which clamps digits above 9. At the count limits the
// counter either wraps or saturates, chosen at build time.
//
// Parameters
//   DIGITS  number of decade stages, 1..8 (range 0 .. 10^DIGITS-1)
//   WRAP    1 = wrap MAX->0 / 0->MAX, 0 = hold at the limit
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   ce        count enable, one step per enabled edge
//   up_dn     direction, 1 = up, 0 = down (sampled when ce=1 and load=0)
//   load      synchronous parallel load from din (beats ce)
//   din       BCD load value, digit 0 in bits [3:0]
//   clr_ovf   synchronous clear of the sticky ovf flag
//   q         current count in BCD, digit 0 least significant
//   bin       binary value of q, one cycle behind q, zero-extended
//   tc        one-cycle pulse after every limit event (wrap or saturate)
//   ovf       sticky flag, set by any limit event
//   load_err  one-cycle pulse after a load whose din held a non-BCD digit
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  clr_ovf,
  output logic [4*DIGITS-1:0]   q,
  output logic [4*DIGITS-1:0]   bin,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // Registered state
  logic [W-1:0]      q_reg;
  logic [W-1:0]      bin_reg;
  logic              tc_reg;
  logic              ovf_reg;
  logic              load_err_reg;

  // Next-state values
  logic [W-1:0]      q_next;
  logic [W-1:0]      bin_next;
  logic              ovf_next;
  logic              load_err_next;

  // Load path: din with each digit clamped to 9
  logic [W-1:0]      load_val;
  logic [DIGITS-1:0] din_bad;

  // Count path
  logic [W-1:0]      step_val;   // q after one step in the up_dn direction
  logic              at_max;     // every digit is 9
  logic              at_zero;    // every digit is 0
  logic              limit_evt;  // this edge hits a count limit

  // Scratch for the combinational digit loops
  logic              all_nine;
  logic              all_zero;
  logic [3:0]        dig;
  logic [3:0]        bin_dig;
  logic [W-1:0]      bin_acc;

  // -------------------------------------------------------------------------
  // Load value: clamp each din digit independently. Also flag any digit
  // that was out of range.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_load_digit
      assign din_bad[gi] = (din[4*gi +: 4] > 4'd9);
      assign load_val[4*gi +: 4] = din_bad[gi] ? 4'd9 : din[4*gi +: 4];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Digit chain. Moving up from digit 0, all_nine / all_zero record whether
  // every lower digit is 9 (up carry) or 0 (down borrow).
  // - Up: a digit steps only when all lower digits are 9.
  // - Down: a digit steps only when all lower digits are 0.
  // After the last digit, the same flags give the MAX and zero detects.
  // At the limits, the plain ripple already produces the wrapped value:
  // up from MAX gives all zeros, and down from 0 gives all nines.
  // -------------------------------------------------------------------------
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    dig      = 4'd0;
    step_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_reg[4*i +: 4];
      if (up_dn) begin
        if (all_nine) begin
          step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : 4'(dig + 4'd1);
        end else begin
          step_val[4*i +: 4] = dig;
        end
      end else begin
        if (all_zero) begin
          step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : 4'(dig - 4'd1);
        end else begin
          step_val[4*i +: 4] = dig;
        end
      end
      all_nine = all_nine & (dig == 4'd9);
      all_zero = all_zero & (dig == 4'd0);
    end
    at_max  = all_nine;
    at_zero = all_zero;
  end

  // A limit event needs an enabled count that is not overridden by load.
  assign limit_evt = ce && !load && (up_dn ? at_max : at_zero);

  // -------------------------------------------------------------------------
  // Next count. Priority: load, then count; otherwise hold.
  // In saturate mode, a limit event leaves q where it is.
  // -------------------------------------------------------------------------
  always_comb begin
    q_next = q_reg;
    if (load) begin
      q_next = load_val;
    end else if (ce) begin
      if (limit_evt && (WRAP == 0)) begin
        q_next = q_reg;
      end else begin
        q_next = step_val;
      end
    end
  end

  // Sticky overflow. When a limit event and clr_ovf share an edge, the set
  // takes precedence.
  always_comb begin
    ovf_next = ovf_reg;
    if (limit_evt) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  assign load_err_next = load && (|din_bad);

  // -------------------------------------------------------------------------
  // Binary image of the current q, folded from the most significant digit
  // down: acc = acc*10 + digit. Every partial result is at most the final
  // value, and 10^DIGITS < 16^DIGITS, so W bits never overflow.
  // -------------------------------------------------------------------------
  always_comb begin
    bin_acc = '0;
    bin_dig = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      bin_dig = q_reg[4*i +: 4];
      bin_acc = W'(bin_acc * W'(10)) + W'(bin_dig);
    end
    bin_next = bin_acc;
  end

  // -------------------------------------------------------------------------
  // State registers. rst clears everything at once, including any pending
  // tc / load_err pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg        <= '0;
      bin_reg      <= '0;
      tc_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      bin_reg      <= bin_next;
      tc_reg       <= limit_evt;
      ovf_reg      <= ovf_next;
      load_err_reg <= load_err_next;
    end
  end

  assign q        = q_reg;
  assign bin      = bin_reg;
  assign tc       = tc_reg;
  assign ovf      = ovf_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Self-checking bench for bcd_updown_counter, using three instances:
//   u_a  DIGITS=2, WRAP=1  : full up count, then a directed vector table
//   u_b  DIGITS=2, WRAP=0  : saturation at both limits
//   u_c  DIGITS=4, WRAP=1  : multi-digit carry/borrow, async reset mid-count
// Inputs are driven 1 time unit after a rising edge. Outputs are checked
// at that same point, which is away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A
  logic       ce_a = 0, up_a = 0, load_a = 0, clr_a = 0;
  logic [7:0] din_a = '0;
  logic [7:0] q_a, bin_a;
  logic       tc_a, ovf_a, lerr_a;
  // Instance B
  logic       ce_b = 0, up_b = 0, load_b = 0, clr_b = 0;
  logic [7:0] din_b = '0;
  logic [7:0] q_b, bin_b;
  logic       tc_b, ovf_b, lerr_b;
  // Instance C
  logic        ce_c = 0, up_c = 0, load_c = 0, clr_c = 0;
  logic [15:0] din_c = '0;
  logic [15:0] q_c, bin_c;
  logic        tc_c, ovf_c, lerr_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .ce(ce_a), .up_dn(up_a), .load(load_a), .din(din_a),
    .clr_ovf(clr_a), .q(q_a), .bin(bin_a), .tc(tc_a), .ovf(ovf_a), .load_err(lerr_a));

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_b (
    .clk(clk), .rst(rst), .ce(ce_b), .up_dn(up_b), .load(load_b), .din(din_b),
    .clr_ovf(clr_b), .q(q_b), .bin(bin_b), .tc(tc_b), .ovf(ovf_b), .load_err(lerr_b));

  bcd_updown_counter #(.DIGITS(4), .WRAP(1)) u_c (
    .clk(clk), .rst(rst), .ce(ce_c), .up_dn(up_c), .load(load_c), .din(din_c),
    .clr_ovf(clr_c), .q(q_c), .bin(bin_c), .tc(tc_c), .ovf(ovf_c), .load_err(lerr_c));

  typedef struct packed {
    logic       load;
    logic       ce;
    logic       up_dn;
    logic       clr_ovf;
    logic [7:0] din;
    logic [7:0] q;     // expected q after the edge (BCD)
    logic [7:0] bin;   // expected bin after the edge (binary)
    logic       tc;
    logic       ovf;
    logic       lerr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  initial begin
    // Directed table for u_a. It starts from q=00, tc=1, ovf=1, bin=99,
    // which is the state after the 100-edge up count.
    //              load ce up clr  din    q      bin    tc ovf lerr
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b1, 8'h00, 8'h00, 8'd0,  1'b0,1'b0,1'b0}; // clear ovf
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 8'h01, 8'h01, 8'd0,  1'b0,1'b0,1'b0}; // load 01
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h00, 8'd1,  1'b0,1'b0,1'b0}; // down -> 00
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h99, 8'd0,  1'b1,1'b1,1'b0}; // down wrap
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h98, 8'd99, 1'b0,1'b1,1'b0}; // down -> 98
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b0, 8'hA3, 8'h93, 8'd98, 1'b0,1'b1,1'b1}; // bad load beats ce
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 8'h00, 8'h93, 8'd93, 1'b0,1'b1,1'b0}; // hold
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0, 8'h99, 8'h99, 8'd93, 1'b0,1'b1,1'b0}; // load 99
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1, 8'h00, 8'h00, 8'd99, 1'b1,1'b1,1'b0}; // wrap + clr: set wins
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1, 8'h00, 8'h00, 8'd0,  1'b0,1'b0,1'b0}; // clr alone
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0, 8'h5F, 8'h59, 8'd0,  1'b0,1'b0,1'b1}; // clamp low digit
    tbl[11] = '{1'b0,1'b1,1'b1,1'b0, 8'h00, 8'h60, 8'd59, 1'b0,1'b0,1'b0}; // up carry
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h59, 8'd60, 1'b0,1'b0,1'b0}; // down borrow
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0, 8'hFF, 8'h99, 8'd59, 1'b0,1'b0,1'b1}; // clamp both
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h99, 8'd99, 1'b0,1'b0,1'b0}; // idle, bin catches up

    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_a_q", q_a, 0);      chk("rst_a_bin", bin_a, 0);
    chk("rst_a_tc", tc_a, 0);    chk("rst_a_ovf", ovf_a, 0);
    chk("rst_a_lerr", lerr_a, 0);
    chk("rst_b_q", q_b, 0);      chk("rst_c_q", q_c, 0);
    rst = 1'b0;

    // ---------------- u_a: 100 up edges ----------------
    ce_a = 1'b1;
    up_a = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk($sformatf("cnt_q[%0d]", k),   q_a,   to_bcd2(k % 100));
      chk($sformatf("cnt_bin[%0d]", k), bin_a, 8'((k - 1) % 100));
      chk($sformatf("cnt_tc[%0d]", k),  tc_a,  (k == 100) ? 1 : 0);
      chk($sformatf("cnt_ovf[%0d]", k), ovf_a, (k == 100) ? 1 : 0);
    end
    ce_a = 1'b0;

    // ---------------- u_a: directed table ----------------
    for (int v = 0; v < NVEC; v++) begin
      load_a = tbl[v].load;
      ce_a   = tbl[v].ce;
      up_a   = tbl[v].up_dn;
      clr_a  = tbl[v].clr_ovf;
      din_a  = tbl[v].din;
      tick();
      chk($sformatf("vec%0d_q", v),    q_a,    tbl[v].q);
      chk($sformatf("vec%0d_bin", v),  bin_a,  tbl[v].bin);
      chk($sformatf("vec%0d_tc", v),   tc_a,   tbl[v].tc);
      chk($sformatf("vec%0d_ovf", v),  ovf_a,  tbl[v].ovf);
      chk($sformatf("vec%0d_lerr", v), lerr_a, tbl[v].lerr);
    end
    load_a = 0; ce_a = 0; clr_a = 0;

    // ---------------- u_b: saturation ----------------
    load_b = 1'b1; din_b = 8'h98;
    tick();
    chk("sat_load_q", q_b, 8'h98);
    load_b = 1'b0; ce_b = 1'b1; up_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("sat_up_q[%0d]", k),   q_b,   8'h99);
      chk($sformatf("sat_up_tc[%0d]", k),  tc_b,  (k >= 2) ? 1 : 0);
      chk($sformatf("sat_up_ovf[%0d]", k), ovf_b, (k >= 2) ? 1 : 0);
    end
    ce_b = 1'b0;
    tick();
    chk("sat_idle_tc", tc_b, 0);
    chk("sat_idle_ovf", ovf_b, 1);
    chk("sat_idle_bin", bin_b, 8'd99);
    load_b = 1'b1; din_b = 8'h00;
    tick();
    chk("sat_load0_q", q_b, 8'h00);
    load_b = 1'b0; ce_b = 1'b1; up_b = 1'b0; clr_b = 1'b1;
    tick();
    chk("sat_dn_q", q_b, 8'h00);
    chk("sat_dn_tc", tc_b, 1);
    chk("sat_dn_ovf", ovf_b, 1);
    ce_b = 1'b0; clr_b = 1'b0;

    // ---------------- u_c: 4-digit ripple ----------------
    load_c = 1'b1; din_c = 16'h9999;
    tick();
    chk("c_load_q", q_c, 16'h9999);
    load_c = 1'b0; ce_c = 1'b1; up_c = 1'b1;
    tick();
    chk("c_wrap_q", q_c, 16'h0000);
    chk("c_wrap_tc", tc_c, 1);
    chk("c_wrap_ovf", ovf_c, 1);
    chk("c_wrap_bin", bin_c, 16'd9999);
    ce_c = 1'b0; load_c = 1'b1; din_c = 16'h0999;
    tick();
    chk("c_load0999_tc", tc_c, 0);
    load_c = 1'b0; ce_c = 1'b1; up_c = 1'b1;
    tick();
    chk("c_carry_q", q_c, 16'h1000);
    up_c = 1'b0;
    tick();
    chk("c_borrow_q", q_c, 16'h0999);
    ce_c = 1'b0; load_c = 1'b1; din_c = 16'h1230;
    tick();
    chk("c_load1230_q", q_c, 16'h1230);
    load_c = 1'b0; ce_c = 1'b1; up_c = 1'b1;
    tick(); tick(); tick();
    ce_b = 1'b1; up_b = 1'b0;     // u_b at 00: gives a tc pulse to cancel
    tick();
    chk("c_1234_q", q_c, 16'h1234);
    chk("c_1234_bin", bin_c, 16'd1233);
    chk("c_1234_ovf", ovf_c, 1);
    chk("b_tc_pending", tc_b, 1);
    ce_b = 1'b0; ce_c = 1'b0;

    // Async reset pulse between edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_c_q", q_c, 0);
    chk("arst_c_bin", bin_c, 0);
    chk("arst_c_tc", tc_c, 0);
    chk("arst_c_ovf", ovf_c, 0);
    chk("arst_b_tc", tc_b, 0);
    #1 rst = 1'b0;
    ce_c = 1'b1; up_c = 1'b1;
    tick();
    chk("resume_q", q_c, 16'h0001);
    chk("resume_bin", bin_c, 16'd0);
    chk("resume_ovf", ovf_c, 0);
    ce_c = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter. It generalises the fixed two-digit up-only decimal counter to DIGITS cascaded decade stages, with a runtime count direction, a parallel BCD load, and a selectable wrap or saturate mode. It also provides a terminal-count pulse, a sticky overflow flag, and a registered binary image of the count. It sits in the miniproject counter/display path, feeding seven-segment drivers (BCD) and comparators (binary).

## Interface
- DIGITS, 2: number of decade stages; legal range 1..8.
- WRAP, 1: 1 = wrap at the count limits; 0 = saturate at the limits.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  count enable; one step per enabled edge.
- up_dn  input  1  count direction; 1 = up, 0 = down; sampled when ce=1.
- load  input  1  synchronous parallel load from din.
- din  input  4*DIGITS  BCD load value; digit 0 is bits [3:0].
- clr_ovf  input  1  synchronous clear of the ovf flag.
- q  output  4*DIGITS  current count in BCD; digit 0 is the least significant.
- bin  output  4*DIGITS  binary value of q, zero-extended.
- tc  output  1  one-cycle terminal-count pulse.
- ovf  output  1  sticky flag; set on any wrap or saturation event.
- load_err  output  1  one-cycle pulse when din held a non-BCD digit.

## Operation
- Count range is 0 to MAX, where MAX = 10^DIGITS − 1. For DIGITS=2, MAX = 99.
- Priority per edge: rst > load > ce. With ce=0 and load=0, q holds.
- Load:
  - q takes din on the edge.
  - Any din digit greater than 9 is clamped to 9, and load_err pulses.
  - tc is not asserted on a load.
  - ovf is unaffected by a load.
- Count up, digit-serial ripple within one cycle:
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - Digit i increments only if every lower digit equals 9.
- Count down:
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - Digit i decrements only if every lower digit equals 0.
- Limit events:
  - An up limit event is ce=1, up_dn=1 with q=MAX.
  - A down limit event is ce=1, up_dn=0 with q=0.
  - With WRAP=1: up goes MAX→0; down goes 0→MAX.
  - With WRAP=0: q holds at the limit.
- On every limit event:
  - tc=1 in the following cycle only.
  - ovf sets.
  - Under WRAP=0, repeated attempts at the limit pulse tc on each enabled edge.
- ovf clearing:
  - clr_ovf=1 clears ovf on the edge.
  - If a limit event and clr_ovf=1 occur on the same edge, set wins and ovf stays 1.
- bin is the registered sum of q digit i × 10^i, computed from the q value present before the edge.
- up_dn is ignored when ce=0 or load=1.
- No internal state besides q, bin, tc, ovf, load_err. No FSM beyond the digit chain.

## Timing
- Reset values while rst=1 (asynchronous, immediate): q=0, bin=0, tc=0, ovf=0, load_err=0.
- Reset release: first state change on the first rising clk after rst falls.
- q latency: 1 edge from ce/load to the new q.
- bin latency: 1 edge behind q. bin equals the binary of q after any 1 idle cycle.
- tc and load_err are registered. Each is high exactly one cycle, following the causing edge.
- ovf is registered. It asserts on the same edge that wraps or saturates q.
- rst asserted mid-count or mid-load: outputs go to reset values at once, and any in-flight tc/load_err pulse is cancelled.
- A direction change on consecutive enabled edges is legal. Each edge uses that edge's up_dn value.

## Test plan
- Reset and count (DIGITS=2, WRAP=1): release rst, hold ce=1, up_dn=1 for 100 edges.
  - q steps 00,01…09,10…99,00.
  - tc pulses once, the cycle after 99→00.
  - ovf=1 from the 99→00 edge onward.
  - bin trails q by one cycle, e.g. bin=45 the cycle after q=0x45.
- Down wrap: load din=0x01, then ce=1, up_dn=0 for 3 edges.
  - q = 0x00, 0x99, 0x98.
  - tc pulses after 0x00→0x99.
  - ovf sets on that edge.
- Saturate (WRAP=0): load 0x98, then ce=1, up_dn=1 for 4 edges.
  - q = 0x99, 0x99, 0x99, 0x99.
  - tc is high for 3 consecutive cycles.
  - ovf=1.
- Invalid load and priority: load=1 with ce=1, din=0xA3.
  - q=0x93; counting is suppressed.
  - load_err pulses for 1 cycle; tc stays 0.
- ovf set/clear collision: q=0x99, up_dn=1, assert ce and clr_ovf on the same edge → ovf stays 1. Next edge with clr_ovf=1, ce=0 → ovf=0.
- Async reset mid-operation (DIGITS=4): count to 0x1234, then pulse rst between clock edges.
  - q, bin, tc, ovf drop to 0 before the next edge.
  - Counting resumes from 0x0000 after release.
